// File: rtl/cfu_rsp_fifo.sv
// -----------------------------------------------------------------------------
// cfu_rsp_fifo
//
// Response buffer between a combinational CFU's response port and the CPU's
// CFU response port. Every CFU result is registered here, which breaks the
// combinational path from the CPU's response ready back through the CFU to
// the CPU's command ready. Holds up to DEPTH results in strict FIFO order and
// exposes occupancy plus a delivered-response counter for debug/perf CSRs.
//
// Parameters:
//   DEPTH  number of entries; power of two, minimum 2
//   WIDTH  payload width in bits
//   AW     pointer width, derived from DEPTH (not overridable)
//
// Ports:
//   clk                    system clock, rising edge
//   reset_n                asynchronous reset, active low
//   clear                  synchronous flush: empties FIFO, zeroes rsp_count
//   in_valid               CFU response valid
//   in_ready               FIFO can accept (drives the CFU's rsp_ready)
//   in_payload_outputs_0   CFU result
//   out_valid              response available to the CPU
//   out_ready              CPU accepts the response
//   out_payload_outputs_0  response data to the CPU
//   level                  current occupancy, 0..DEPTH
//   rsp_count              responses delivered (pop count), wraps mod 2^32
// -----------------------------------------------------------------------------
module cfu_rsp_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_payload_outputs_0,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_payload_outputs_0,
   output logic [AW:0]      level,
   output logic [31:0]      rsp_count
);

   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [31:0]      rsp_count_q, rsp_count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic push;
   logic pop;
   logic mem_we;

   // Handshake flags come only from registered occupancy, so neither ready
   // nor valid depends combinationally on the opposite side. A full FIFO
   // refuses a push even when a pop happens in the same cycle.
   assign in_ready  = (level_q != LEVEL_FULL);
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // clear wins over a concurrent push, so the write is suppressed too.
   assign mem_we    = push & ~clear;

   assign out_payload_outputs_0 = mem_q[rd_ptr_q];
   assign level                 = level_q;
   assign rsp_count             = rsp_count_q;

   // Next-state logic
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      rsp_count_d = rsp_count_q;

      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         rsp_count_d = '0;
      end else begin
         // Pointers are exactly AW bits and DEPTH is a power of two, so the
         // natural overflow wraps DEPTH-1 -> 0 with no extra compare.
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            rsp_count_d = rsp_count_q + 32'd1;
         end
         unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         rsp_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         rsp_count_q <= rsp_count_d;
      end
   end

   // Storage array
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the array is reset only because it is a handful of flops and
      // out_payload_outputs_0 reads it directly; zeroing it keeps the output
      // at 0 (never X) after reset. Larger storage would be left unreset.
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[wr_ptr_q] <= in_payload_outputs_0;
      end
   end

endmodule

// File: tb/tb_cfu_rsp_fifo.sv
// -----------------------------------------------------------------------------
// tb_cfu_rsp_fifo
//
// Self-checking bench for cfu_rsp_fifo. Two instances share clock and reset:
// u_dut2 (DEPTH=2) runs a table of per-cycle vectors (pass-through, streaming
// with pointer wrap, simultaneous push/pop, full without pass-through);
// u_dut4 (DEPTH=4) runs hand-written back-pressure, clear and async-reset
// sequences. Inputs change 1 ns after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_cfu_rsp_fifo;

   typedef struct {
      logic        iv;
      logic        ordy;
      logic [31:0] pl;
      logic        e_ir;
      logic        e_ov;
      logic [2:0]  e_lvl;
      logic [31:0] e_cnt;
      logic        chk;
      logic [31:0] e_data;
   } vec_t;

   logic clk;
   logic reset_n;

   // DEPTH=2 instance
   logic        clr2, iv2, ir2, ov2, or2;
   logic [31:0] pli2, plo2, cnt2;
   logic [1:0]  lvl2;

   // DEPTH=4 instance
   logic        clr4, iv4, ir4, ov4, or4;
   logic [31:0] pli4, plo4, cnt4;
   logic [2:0]  lvl4;

   int tests;
   int fails;

   vec_t vecs[$];

   cfu_rsp_fifo #(.DEPTH(2), .WIDTH(32)) u_dut2 (
      .clk                   (clk),
      .reset_n               (reset_n),
      .clear                 (clr2),
      .in_valid              (iv2),
      .in_ready              (ir2),
      .in_payload_outputs_0  (pli2),
      .out_valid             (ov2),
      .out_ready             (or2),
      .out_payload_outputs_0 (plo2),
      .level                 (lvl2),
      .rsp_count             (cnt2)
   );

   cfu_rsp_fifo #(.DEPTH(4), .WIDTH(32)) u_dut4 (
      .clk                   (clk),
      .reset_n               (reset_n),
      .clear                 (clr4),
      .in_valid              (iv4),
      .in_ready              (ir4),
      .in_payload_outputs_0  (pli4),
      .out_valid             (ov4),
      .out_ready             (or4),
      .out_payload_outputs_0 (plo4),
      .level                 (lvl4),
      .rsp_count             (cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic ordy, input logic [31:0] pl,
                               input logic e_ir, input logic e_ov, input logic [2:0] e_lvl,
                               input logic [31:0] e_cnt, input logic chk,
                               input logic [31:0] e_data);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.pl = pl;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_lvl = e_lvl;
      v.e_cnt = e_cnt; v.chk = chk; v.e_data = e_data;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] t2_fill [4];
      logic [31:0] t2_exp  [5];
      vec_t        v;
      int          got;
      logic        accept;

      tests = 0;
      fails = 0;
      t2_fill = '{32'h11, 32'h22, 32'h33, 32'h44};
      t2_exp  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

      // Expected outputs are the pre-edge state for each vector's inputs.
      // Test 1: single pass-through.
      vecs.push_back(mk(1'b1, 1'b1, 32'h1FE, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 32'h0,   1'b1, 1'b1, 3'd1, 32'd0, 1'b1, 32'h1FE));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 3'd0, 32'd1, 1'b0, 32'h0));
      // Test 3: full-rate streaming of 0..9; each cycle shows the previous value.
      for (int k = 0; k < 10; k++) begin
         vecs.push_back(mk(1'b1, 1'b1, 32'(k), 1'b1, k > 0, 3'(k > 0),
                           (k == 0) ? 32'd1 : 32'(k), k > 0, 32'(k - 1)));
      end
      vecs.push_back(mk(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 3'd1, 32'd10, 1'b1, 32'd9));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 32'd11, 1'b0, 32'h0));
      // Test 4: push+pop at level 1, then full with a pop that must not let a push in.
      vecs.push_back(mk(1'b1, 1'b0, 32'hA0, 1'b1, 1'b0, 3'd0, 32'd11, 1'b0, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 32'hA1, 1'b1, 1'b1, 3'd1, 32'd11, 1'b1, 32'hA0));
      vecs.push_back(mk(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 3'd1, 32'd12, 1'b1, 32'hA1));
      vecs.push_back(mk(1'b1, 1'b1, 32'hA3, 1'b0, 1'b1, 3'd2, 32'd12, 1'b1, 32'hA1));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 3'd1, 32'd13, 1'b1, 32'hA2));
      vecs.push_back(mk(1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 3'd1, 32'd13, 1'b1, 32'hA2));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 3'd0, 32'd14, 1'b0, 32'h0));

      // Reset: state must be cleared asynchronously, before any clock edge.
      reset_n = 1'b0;
      clr2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; pli2 = '0;
      clr4 = 1'b0; iv4 = 1'b0; or4 = 1'b0; pli4 = '0;
      #1;
      check("rst_in_ready2",  32'(ir2),  32'd1);
      check("rst_out_valid2", 32'(ov2),  32'd0);
      check("rst_level2",     32'(lvl2), 32'd0);
      check("rst_count2",     cnt2,      32'd0);
      check("rst_payload2",   plo2,      32'd0);
      check("rst_in_ready4",  32'(ir4),  32'd1);
      check("rst_out_valid4", 32'(ov4),  32'd0);
      check("rst_level4",     32'(lvl4), 32'd0);
      check("rst_payload4",   plo4,      32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Table-driven vectors on the DEPTH=2 instance.
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         iv2 = v.iv; or2 = v.ordy; pli2 = v.pl;
         @(negedge clk);
         check($sformatf("v%0d_in_ready", i),  32'(ir2),  32'(v.e_ir));
         check($sformatf("v%0d_out_valid", i), 32'(ov2),  32'(v.e_ov));
         check($sformatf("v%0d_level", i),     32'(lvl2), 32'(v.e_lvl));
         check($sformatf("v%0d_rsp_count", i), cnt2,      v.e_cnt);
         if (v.chk) begin
            check($sformatf("v%0d_payload", i), plo2, v.e_data);
         end
         tick();
      end
      iv2 = 1'b0; or2 = 1'b0;

      // Test 2: fill DEPTH=4, hold a fifth push under back-pressure.
      or4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         iv4 = 1'b1; pli4 = t2_fill[k];
         @(negedge clk);
         check($sformatf("t2_fill%0d_in_ready", k), 32'(ir4), 32'd1);
         tick();
      end
      pli4 = 32'h55;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t2_hold%0d_in_ready", k), 32'(ir4),  32'd0);
         check($sformatf("t2_hold%0d_level", k),    32'(lvl4), 32'd4);
         check($sformatf("t2_hold%0d_payload", k),  plo4,      32'h11);
         tick();
      end
      or4 = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("t2_first_pop_in_ready", 32'(ir4), 32'd0);
         end
         if (ov4) begin
            check($sformatf("t2_out%0d", got), plo4, t2_exp[got]);
            got++;
         end
         accept = iv4 & ir4;
         tick();
         if (accept) iv4 = 1'b0;
      end
      or4 = 1'b0;
      check("t2_delivered", 32'(got), 32'd5);
      @(negedge clk);
      check("t2_level_end", 32'(lvl4), 32'd0);
      check("t2_rsp_count", cnt4,      32'd5);
      check("t2_in_valid_consumed", 32'(iv4), 32'd0);
      tick();

      // Test 5: clear at level 3 with concurrent push and pop.
      for (int k = 0; k < 3; k++) begin
         iv4 = 1'b1; pli4 = 32'hAA + 32'(k * 17);
         tick();
      end
      iv4 = 1'b0;
      @(negedge clk);
      check("t5_level_pre", 32'(lvl4), 32'd3);
      tick();
      clr4 = 1'b1; iv4 = 1'b1; pli4 = 32'hDD; or4 = 1'b1;
      tick();
      clr4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
      @(negedge clk);
      check("t5_level",     32'(lvl4), 32'd0);
      check("t5_out_valid", 32'(ov4),  32'd0);
      check("t5_rsp_count", cnt4,      32'd0);
      check("t5_in_ready",  32'(ir4),  32'd1);
      tick();
      iv4 = 1'b1; pli4 = 32'hEE;
      tick();
      iv4 = 1'b0;
      @(negedge clk);
      check("t5_next_valid",   32'(ov4),  32'd1);
      check("t5_next_payload", plo4,      32'hEE);
      check("t5_next_level",   32'(lvl4), 32'd1);
      tick();
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      @(negedge clk);
      check("t5_count_after_pop", cnt4,      32'd1);
      check("t5_level_after_pop", 32'(lvl4), 32'd0);
      tick();

      // Test 6: asynchronous reset at level 2, between clock edges.
      iv4 = 1'b1; pli4 = 32'h12;
      tick();
      pli4 = 32'h34;
      tick();
      iv4 = 1'b0;
      @(negedge clk);
      check("t6_level_pre", 32'(lvl4), 32'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async_out_valid", 32'(ov4),  32'd0);
      check("t6_async_level",     32'(lvl4), 32'd0);
      check("t6_async_in_ready",  32'(ir4),  32'd1);
      check("t6_async_count",     cnt4,      32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      iv4 = 1'b1; pli4 = 32'hDEADBEEF;
      tick();
      iv4 = 1'b0;
      @(negedge clk);
      check("t6_first_valid",   32'(ov4),  32'd1);
      check("t6_first_payload", plo4,      32'hDEADBEEF);
      check("t6_first_level",   32'(lvl4), 32'd1);
      force u_dut4.rsp_count_q = 32'hFFFFFFFF;
      #1;
      release u_dut4.rsp_count_q;
      #1;
      check("t6_count_preset", cnt4, 32'hFFFFFFFF);
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
      @(negedge clk);
      check("t6_count_wrap",  cnt4,      32'd0);
      check("t6_level_final", 32'(lvl4), 32'd0);
      check("t6_valid_final", 32'(ov4),  32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
